instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instr_fetch_pkg.sv | 11 +
 rtl/fetch_out_buffer.sv | 78 +++++++
 rtl/instruction_fetch.sv | 81 ++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Instruction fetch shared constants.
// Default geometry and output buffer sizing.
package instr_fetch_pkg;

  localparam int ADDR_WIDTH    = 3;
  localparam int DATA_WIDTH    = 10;
  localparam int DEPTH         = 1 << ADDR_WIDTH;
  localparam int OUT_BUF_DEPTH = 2;
  localparam int CNT_WIDTH     = $clog2(OUT_BUF_DEPTH + 1);

endpackage

// File: rtl/fetch_out_buffer.sv
// Two-entry in-order buffer of fetched words.
// Each entry carries the word and its fetch address.
module fetch_out_buffer
  import instr_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = instr_fetch_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = instr_fetch_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [DATA_WIDTH-1:0] hd_data;
  logic [DATA_WIDTH-1:0] tl_data;
  logic [ADDR_WIDTH-1:0] hd_pc;
  logic [ADDR_WIDTH-1:0] tl_pc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  do_pop;

  assign do_pop = pop && (cnt != '0);
  assign valid  = cnt != '0;
  assign data   = hd_data;
  assign pc     = hd_pc;
  assign count  = cnt;

  // Head register is the presented entry; tail only fills when head busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      hd_data <= '0;
      hd_pc   <= '0;
      tl_data <= '0;
      tl_pc   <= '0;
      cnt     <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        push && do_pop: begin
          if (cnt == CNT_WIDTH'(1)) begin
            hd_data <= push_data;
            hd_pc   <= push_pc;
          end else begin
            hd_data <= tl_data;
            hd_pc   <= tl_pc;
            tl_data <= push_data;
            tl_pc   <= push_pc;
          end
        end
        push && !do_pop: begin
          if (cnt == '0) begin
            hd_data <= push_data;
            hd_pc   <= push_pc;
          end else begin
            tl_data <= push_data;
            tl_pc   <= push_pc;
          end
          cnt <= cnt + 1'b1;
        end
        !push && do_pop: begin
          hd_data <= tl_data;
          hd_pc   <= tl_pc;
          cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Sequential instruction fetch with redirect support.
// Issues one read per cycle while buffer space allows.
module instruction_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH      = instr_fetch_pkg::DEPTH,
  parameter int DATA_WIDTH = instr_fetch_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = instr_fetch_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  rd_en;
  logic                  pop;
  logic                  capture;
  logic [CNT_WIDTH-1:0]  buf_count;
  logic [CNT_WIDTH:0]    occupancy;

  assign pop = instr_valid && instr_ready;

  // Slots committed after this cycle: stored plus returning minus leaving.
  assign occupancy = {1'b0, buf_count}
                   + (CNT_WIDTH+1)'(inflight)
                   - (CNT_WIDTH+1)'(pop);

  assign rd_en = !rst && fetch_en && !redirect_valid
              && (occupancy < (CNT_WIDTH+1)'(OUT_BUF_DEPTH));

  assign capture = inflight && !redirect_valid;

  assign pc_inc = (pc == ADDR_WIDTH'(DEPTH-1)) ? '0 : pc + 1'b1;

  assign imem_rd_en = rd_en;
  assign imem_addr  = rst ? '0 : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= rd_en;
      if (rd_en) inflight_pc <= pc;
      if (redirect_valid) pc <= redirect_addr;
      else if (rd_en)     pc <= pc_inc;
    end
  end

  fetch_out_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (capture),
    .push_data(imem_data),
    .push_pc  (inflight_pc),
    .pop      (pop),
    .valid    (instr_valid),
    .data     (instr_data),
    .pc       (instr_pc),
    .count    (buf_count)
  );

endmodule
